// File: rtl/vdp_pkg.sv
// vdp_pkg: shared VGA 640x480@60 timing, framebuffer geometry and colour type
package vdp_pkg;
  localparam int H_VIS = 640;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int V_VIS = 480;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int FB_W = 280;
  localparam int FB_H = 192;
  typedef logic [23:0] rgb_t;
endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel-tick phase, h/v counters and VGA sync/visibility flags
module vga_timing #(
  parameter int H_VIS = vdp_pkg::H_VIS,
  parameter int H_FP = vdp_pkg::H_FP,
  parameter int H_SYNC = vdp_pkg::H_SYNC,
  parameter int H_BP = vdp_pkg::H_BP,
  parameter int V_VIS = vdp_pkg::V_VIS,
  parameter int V_FP = vdp_pkg::V_FP,
  parameter int V_SYNC = vdp_pkg::V_SYNC,
  parameter int V_BP = vdp_pkg::V_BP
) (
  input logic clk_i,
  input logic rst_i,
  output logic tick_o,
  output logic [9:0] h_o,
  output logic [9:0] v_o,
  output logic visible_o,
  output logic hs_act_o,
  output logic vs_act_o,
  output logic vblank_o,
  output logic frame_start_o
);
  localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  logic ph_q, fs_q;
  logic [9:0] h_q, h_d, v_q, v_d;
  always_comb begin
    h_d = ph_q ? (h_q == H_LAST ? '0 : h_q + 10'd1) : h_q;
    v_d = (ph_q && h_q == H_LAST) ? (v_q == V_LAST ? '0 : v_q + 10'd1) : v_q;
  end
  // frame_start is registered one cycle early so it lands on the tick at (0,0)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ph_q <= 1'b0;
      h_q <= '0;
      v_q <= '0;
      fs_q <= 1'b0;
    end else begin
      ph_q <= ~ph_q;
      h_q <= h_d;
      v_q <= v_d;
      fs_q <= ~ph_q && h_q == '0 && v_q == '0;
    end
  end
  assign tick_o = ph_q;
  assign h_o = h_q;
  assign v_o = v_q;
  assign visible_o = h_q < 10'(H_VIS) && v_q < 10'(V_VIS);
  assign hs_act_o = h_q >= 10'(H_VIS + H_FP) && h_q < 10'(H_VIS + H_FP + H_SYNC);
  assign vs_act_o = v_q >= 10'(V_VIS + V_FP) && v_q < 10'(V_VIS + V_FP + V_SYNC);
  assign vblank_o = v_q >= 10'(V_VIS);
  assign frame_start_o = fs_q;
endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: 2x-doubled, centred framebuffer scanout onto VGA DAC pins
module fb_scanout #(
  parameter int FB_W = vdp_pkg::FB_W,
  parameter int FB_H = vdp_pkg::FB_H,
  parameter int X_OFF = 40,
  parameter int Y_OFF = 48,
  parameter vdp_pkg::rgb_t BORDER = 24'h000000,
  parameter int AW = 16,
  parameter int H_VIS = vdp_pkg::H_VIS,
  parameter int H_FP = vdp_pkg::H_FP,
  parameter int H_SYNC = vdp_pkg::H_SYNC,
  parameter int H_BP = vdp_pkg::H_BP,
  parameter int V_VIS = vdp_pkg::V_VIS,
  parameter int V_FP = vdp_pkg::V_FP,
  parameter int V_SYNC = vdp_pkg::V_SYNC,
  parameter int V_BP = vdp_pkg::V_BP
) (
  input logic CLOCK_50,
  input logic reset,
  output logic [AW-1:0] vram_adr,
  input vdp_pkg::rgb_t vram_q,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic VGA_CLK,
  output logic VGA_BLANK_N,
  output logic VGA_SYNC_N,
  output logic VGA_HS,
  output logic VGA_VS,
  output logic frame_start,
  output logic vblank
);
  import vdp_pkg::rgb_t;
  logic tick, visible, hs_act, vs_act, in_win;
  logic [9:0] h, v, fx, fy;
  logic [AW-1:0] adr_d, adr_q;
  logic win_q, vis_q, hs_q, vs_q, blank_n_q, hs_n_q, vs_n_q;
  rgb_t rgb_d, rgb_q;
  vga_timing #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk_i(CLOCK_50),
    .rst_i(reset),
    .tick_o(tick),
    .h_o(h),
    .v_o(v),
    .visible_o(visible),
    .hs_act_o(hs_act),
    .vs_act_o(vs_act),
    .vblank_o(vblank),
    .frame_start_o(frame_start)
  );
  always_comb begin
    in_win = h >= 10'(X_OFF) && h < 10'(X_OFF + 2 * FB_W) &&
             v >= 10'(Y_OFF) && v < 10'(Y_OFF + 2 * FB_H);
    fx = (h - 10'(X_OFF)) >> 1;
    fy = (v - 10'(Y_OFF)) >> 1;
    adr_d = in_win ? AW'(32'(fy) * 32'(FB_W) + 32'(fx)) : '0;
    rgb_d = win_q ? vram_q : vis_q ? BORDER : '0;
  end
  // stage 1 issues the read; stage 2 picks up vram_q on the following tick
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      adr_q <= '0;
      win_q <= 1'b0;
      vis_q <= 1'b0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      rgb_q <= '0;
      blank_n_q <= 1'b0;
      hs_n_q <= 1'b1;
      vs_n_q <= 1'b1;
    end else if (tick) begin
      adr_q <= adr_d;
      win_q <= in_win;
      vis_q <= visible;
      hs_q <= hs_act;
      vs_q <= vs_act;
      rgb_q <= rgb_d;
      blank_n_q <= vis_q;
      hs_n_q <= ~hs_q;
      vs_n_q <= ~vs_q;
    end
  end
  assign vram_adr = adr_q;
  assign {VGA_R, VGA_G, VGA_B} = rgb_q;
  assign VGA_CLK = tick;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N = 1'b0;
  assign VGA_HS = hs_n_q;
  assign VGA_VS = vs_n_q;
endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: full-size and scaled-down scanout checked cycle by cycle against an arithmetic model
module tb_fb_scanout;
  typedef struct packed {int hv, hf, hs, hb, vv, vf, vs, vb, fw, fh, xo, yo; logic [23:0] bd;} geo_t;
  typedef struct {bit vis, hsl, vsl, win; int v, adr;} px_t;
  localparam geo_t GB = '{640, 16, 96, 48, 480, 10, 2, 33, 280, 192, 40, 48, 24'h000000};
  localparam geo_t GS = '{64, 4, 8, 4, 32, 2, 2, 3, 20, 12, 8, 6, 24'h0000ff};
  logic clk = 1'b0, reset = 1'b1, ff_mode = 1'b0, seg1 = 1'b1;
  longint n = 0, last_fs = -1;
  int checks = 0, failures = 0, hs_lo = 0, bn_hi = 0;
  logic [23:0] rnd [65536];
  logic [15:0] adr_b, adr_s;
  logic [23:0] q_b, q_s;
  logic [7:0] r_b, g_b, b_b, r_s, g_s, b_s;
  logic vclk_b, bn_b, sn_b, hs_b, vs_b, fs_b, vb_b;
  logic vclk_s, bn_s, sn_s, hs_s, vs_s, fs_s, vb_s;
  always #10 clk = ~clk;
  fb_scanout u_big (
    .CLOCK_50(clk), .reset(reset), .vram_adr(adr_b), .vram_q(q_b),
    .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b), .VGA_CLK(vclk_b), .VGA_BLANK_N(bn_b),
    .VGA_SYNC_N(sn_b), .VGA_HS(hs_b), .VGA_VS(vs_b), .frame_start(fs_b), .vblank(vb_b)
  );
  fb_scanout #(
    .FB_W(20), .FB_H(12), .X_OFF(8), .Y_OFF(6), .BORDER(24'h0000ff),
    .H_VIS(64), .H_FP(4), .H_SYNC(8), .H_BP(4), .V_VIS(32), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_sml (
    .CLOCK_50(clk), .reset(reset), .vram_adr(adr_s), .vram_q(q_s),
    .VGA_R(r_s), .VGA_G(g_s), .VGA_B(b_s), .VGA_CLK(vclk_s), .VGA_BLANK_N(bn_s),
    .VGA_SYNC_N(sn_s), .VGA_HS(hs_s), .VGA_VS(vs_s), .frame_start(fs_s), .vblank(vb_s)
  );
  function automatic logic [23:0] memv(input logic [15:0] a);
    return ff_mode ? 24'hffffff : rnd[a];
  endfunction
  always @(posedge clk) begin
    q_b <= memv(adr_b);
    q_s <= memv(adr_s);
  end
  function automatic px_t pix(input geo_t g, input longint k);
    px_t p;
    int ht, vt, h, v;
    ht = g.hv + g.hf + g.hs + g.hb;
    vt = g.vv + g.vf + g.vs + g.vb;
    h = int'(k % ht);
    v = int'((k / ht) % vt);
    p.v = v;
    p.vis = h < g.hv && v < g.vv;
    p.hsl = h >= g.hv + g.hf && h < g.hv + g.hf + g.hs;
    p.vsl = v >= g.vv + g.vf && v < g.vv + g.vf + g.vs;
    p.win = h >= g.xo && h < g.xo + 2 * g.fw && v >= g.yo && v < g.yo + 2 * g.fh;
    p.adr = p.win ? ((v - g.yo) / 2) * g.fw + (h - g.xo) / 2 : 0;
    return p;
  endfunction
  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask
  task automatic chk(input geo_t g, input string nm, input logic [15:0] adr, input logic [23:0] rgb,
                     input logic vclk, input logic bn, input logic sn, input logic hs, input logic vs,
                     input logic fs, input logic vb);
    px_t pa, po;
    longint ft;
    logic [23:0] er;
    ft = longint'(g.hv + g.hf + g.hs + g.hb) * (g.vv + g.vf + g.vs + g.vb);
    pa = pix(g, n < 2 ? 0 : (n - 2) / 2);
    po = pix(g, n < 4 ? 0 : (n - 4) / 2);
    er = n < 4 ? 24'h0 : po.win ? memv(16'(po.adr)) : po.vis ? g.bd : 24'h0;
    cmp({nm, ".vram_adr"}, 32'(adr), n < 2 ? 0 : pa.adr);
    cmp({nm, ".rgb"}, 32'(rgb), 32'(er));
    cmp({nm, ".blank_n"}, 32'(bn), 32'(n >= 4 && po.vis));
    cmp({nm, ".hs"}, 32'(hs), 32'(n < 4 || !po.hsl));
    cmp({nm, ".vs"}, 32'(vs), 32'(n < 4 || !po.vsl));
    cmp({nm, ".vga_clk"}, 32'(vclk), 32'(n[0]));
    cmp({nm, ".sync_n"}, 32'(sn), 0);
    cmp({nm, ".vblank"}, 32'(vb), 32'(pix(g, n / 2).v >= g.vv));
    cmp({nm, ".frame_start"}, 32'(fs), 32'(n[0] && ((n - 1) / 2) % ft == 0));
  endtask
  task automatic cyc();
    @(posedge clk);
    n = reset ? 0 : n + 1;
    @(negedge clk);
    chk(GB, "big", adr_b, {r_b, g_b, b_b}, vclk_b, bn_b, sn_b, hs_b, vs_b, fs_b, vb_b);
    chk(GS, "sml", adr_s, {r_s, g_s, b_s}, vclk_s, bn_s, sn_s, hs_s, vs_s, fs_s, vb_s);
    if (seg1 && n >= 4 && n < 1604) begin
      hs_lo += int'(!hs_b);
      bn_hi += int'(bn_b);
    end
    if (fs_s === 1'b1) begin
      if (seg1 && last_fs >= 0) cmp("sml.frame_period", 32'(n - last_fs), 6240);
      last_fs = n;
    end
  endtask
  initial begin
    for (int i = 0; i < 65536; i++) rnd[i] = 24'($urandom);
    repeat (3) cyc();
    reset = 1'b0;
    repeat (13000) cyc();
    seg1 = 1'b0;
    cmp("big.hs_low_cycles_line0", hs_lo, 192);
    cmp("big.blank_high_cycles_line0", bn_hi, 1280);
    repeat ($urandom_range(1000, 5000)) cyc();
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    repeat (7000) cyc();
    reset = 1'b1;
    ff_mode = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    repeat (7000) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
